// File: rtl/sim_dram_timing_model_if.sv
// Request/response bundle for the multi-channel DRAM timing model.
// Channel c occupies slice [c*W +: W] of every packed vector.
interface sim_dram_timing_model_if #(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned DATA_WIDTH   = 512
);
  logic [NUM_CHANNELS-1:0]            req_valid;
  logic [NUM_CHANNELS-1:0]            req_is_write;
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] req_data;
  logic [NUM_CHANNELS-1:0]            req_grant;
  logic [NUM_CHANNELS-1:0]            resp_valid;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] resp_data;
  logic [NUM_CHANNELS-1:0]            resp_grant;
  logic [NUM_CHANNELS*32-1:0]         rd_count;
  logic [NUM_CHANNELS*32-1:0]         wr_count;

  modport master (
    output req_valid, req_is_write, req_addr, req_data, resp_grant,
    input  req_grant, resp_valid, resp_data, rd_count, wr_count
  );

  modport slave (
    input  req_valid, req_is_write, req_addr, req_data, resp_grant,
    output req_grant, resp_valid, resp_data, rd_count, wr_count
  );
endinterface

// File: rtl/sim_dram_timing_model.sv
// Per-channel DRAM model: backing store, fixed read latency, grant throttling
// and credit-protected response FIFO. Channels share nothing.
module sim_dram_timing_model #(
  parameter int unsigned NUM_CHANNELS   = 2,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned MEM_LOG_WORDS  = 10,
  parameter int unsigned READ_LATENCY   = 4,
  parameter int unsigned RESP_LOG_DEPTH = 4,
  parameter int unsigned MIN_GAP        = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  sim_dram_timing_model_if.slave     mem_if
);
  localparam int unsigned MEM_WORDS  = 1 << MEM_LOG_WORDS;
  localparam int unsigned RESP_DEPTH = 1 << RESP_LOG_DEPTH;
  localparam int unsigned PTR_W      = RESP_LOG_DEPTH;
  localparam int unsigned CRED_W     = RESP_LOG_DEPTH + 1;
  localparam int unsigned GAP_W      = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [MEM_LOG_WORDS-1:0] word;
    logic [DATA_WIDTH-1:0]    wdata;
    logic                     grant, rd_grant, wr_grant, push, pop, resp_vld;

    logic [DATA_WIDTH-1:0]    mem_q [MEM_WORDS];
    logic [DATA_WIDTH-1:0]    pipe_data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]    fifo_q [RESP_DEPTH];
    logic [READ_LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CRED_W-1:0]        fill_q, fill_d, credits_q, credits_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic [31:0]              rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    assign word     = mem_if.req_addr[c*ADDR_WIDTH +: MEM_LOG_WORDS];
    assign wdata    = mem_if.req_data[c*DATA_WIDTH +: DATA_WIDTH];
    assign grant    = mem_if.req_valid[c] && !rst && (gap_q == '0) &&
                      (mem_if.req_is_write[c] || (credits_q != '0));
    assign wr_grant = grant && mem_if.req_is_write[c];
    assign rd_grant = grant && !mem_if.req_is_write[c];
    assign resp_vld = (fill_q != '0);
    assign push     = pipe_vld_q[READ_LATENCY-1];
    assign pop      = resp_vld && mem_if.resp_grant[c];

    always_comb begin
      pipe_vld_d = '0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;
      credits_d  = credits_q;
      gap_d      = gap_q;
      rd_cnt_d   = rd_cnt_q;
      wr_cnt_d   = wr_cnt_q;

      pipe_vld_d[0] = rd_grant;
      for (int i = 1; i < READ_LATENCY; i++) pipe_vld_d[i] = pipe_vld_q[i-1];

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      fill_d = fill_q + CRED_W'(1);
      else if (pop && !push) fill_d = fill_q - CRED_W'(1);

      // Credits bound total in-flight reads, so the FIFO can never overflow.
      if (rd_grant && !pop)      credits_d = credits_q - CRED_W'(1);
      else if (pop && !rd_grant) credits_d = credits_q + CRED_W'(1);

      if (grant)              gap_d = GAP_W'(MIN_GAP);
      else if (gap_q != '0)   gap_d = gap_q - GAP_W'(1);

      if (rd_grant && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 32'd1;
      if (wr_grant && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_vld_q <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fill_q     <= '0;
        credits_q  <= CRED_W'(RESP_DEPTH);
        gap_q      <= '0;
        rd_cnt_q   <= '0;
        wr_cnt_q   <= '0;
      end else begin
        pipe_vld_q <= pipe_vld_d;
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        fill_q     <= fill_d;
        credits_q  <= credits_d;
        gap_q      <= gap_d;
        rd_cnt_q   <= rd_cnt_d;
        wr_cnt_q   <= wr_cnt_d;
      end
    end

    // Storage is never reset; validity is carried by the control state above.
    always_ff @(posedge clk) begin
      if (wr_grant) mem_q[word] <= wdata;
      pipe_data_q[0] <= mem_q[word];
      for (int i = 1; i < READ_LATENCY; i++) pipe_data_q[i] <= pipe_data_q[i-1];
      if (push) fifo_q[wr_ptr_q] <= pipe_data_q[READ_LATENCY-1];
    end

    assign mem_if.req_grant[c]                         = grant;
    assign mem_if.resp_valid[c]                        = resp_vld;
    assign mem_if.resp_data[c*DATA_WIDTH +: DATA_WIDTH] = resp_vld ? fifo_q[rd_ptr_q] : '0;
    assign mem_if.rd_count[c*32 +: 32]                 = rd_cnt_q;
    assign mem_if.wr_count[c*32 +: 32]                 = wr_cnt_q;
  end
endmodule
